// File: rtl/luces_pkg.sv
// Shared types and constants for the LED chaser sequencing controller.
package luces_pkg;

    typedef enum logic {
        ST_PAUSE = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    localparam int SPEED_W = 3;

    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;
    localparam logic [SPEED_W-1:0] SPEED_MIN = 3'd0;

    // Last value of the tick counter for a speed level: 7 base ticks at speed 0 down to 0 at speed 7.
    function automatic logic [SPEED_W-1:0] tick_limit(input logic [SPEED_W-1:0] speed);
        return SPEED_MAX - speed;
    endfunction

endpackage

// File: rtl/luces_seq_ctrl_key_pulse.sv
// key_pulse: turns one active-low board key into a single-cycle press pulse.
// 2-FF synchronizer, optional stability filter (macro DEBOUNCE_EN), falling-edge
// detector and a registered output. Holding a key gives one pulse; release gives none.
module key_pulse #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic KEY_N,
    output logic PRESS
);

`ifdef DEBOUNCE_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    localparam int             DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             lvl_prev_q;
    logic             press_q, press_d;
    logic             level_s;

    // Filter the synchronized level and detect the high-to-low transition.
    always_comb begin
        filt_d    = filt_q;
        deb_cnt_d = '0;
        if (sync2_q != filt_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                filt_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end else begin
            deb_cnt_d = '0;
        end
        level_s = FILTER_ON ? filt_q : sync2_q;
        press_d = lvl_prev_q & ~level_s;
    end

    // Synchronizer, filter state, edge history and registered press pulse; keys idle high.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            filt_q     <= 1'b1;
            deb_cnt_q  <= '0;
            lvl_prev_q <= 1'b1;
            press_q    <= 1'b0;
        end else begin
            sync1_q    <= KEY_N;
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            deb_cnt_q  <= deb_cnt_d;
            lvl_prev_q <= level_s;
            press_q    <= press_d;
        end
    end

    assign PRESS = press_q;

endmodule

// File: rtl/luces_seq_ctrl.sv
// luces_seq_ctrl: run/pause sequencer producing the chaser ENABLE strobe.
// Speed 0..7 sets the strobe period to DIV_BASE*(8-SPEED) cycles while running;
// single-step while paused. Key debounce is selected with macro DEBOUNCE_EN.
module luces_seq_ctrl
    import luces_pkg::*;
#(
    parameter int DIV_BASE   = 6_250_000,
    parameter int SPEED_RST  = 3,
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               KEY_RUN,
    input  logic               KEY_STEP,
    input  logic               KEY_UP,
    input  logic               KEY_DOWN,
    output logic               ENABLE,
    output logic [SPEED_W-1:0] SPEED,
    output logic               RUNNING
);

    localparam int               BASE_W    = (DIV_BASE > 1) ? $clog2(DIV_BASE) : 1;
    localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(DIV_BASE - 1);

    logic run_p, step_p, up_p, dn_p;

    key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_key_run  (.CLK(CLK), .RSTn(RSTn), .KEY_N(KEY_RUN),  .PRESS(run_p));
    key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_key_step (.CLK(CLK), .RSTn(RSTn), .KEY_N(KEY_STEP), .PRESS(step_p));
    key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_key_up   (.CLK(CLK), .RSTn(RSTn), .KEY_N(KEY_UP),   .PRESS(up_p));
    key_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_key_dn   (.CLK(CLK), .RSTn(RSTn), .KEY_N(KEY_DOWN), .PRESS(dn_p));

    state_e              state_q, state_d;
    logic [SPEED_W-1:0]  speed_q, speed_d;
    logic [BASE_W-1:0]   base_cnt_q, base_cnt_d;
    logic [SPEED_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic                enable_q, enable_d;

    logic up_ok_s, dn_ok_s, clear_s, base_wrap_s, period_wrap_s;

    // Next state, speed, period counters and strobe.
    always_comb begin
        state_d  = state_q;
        enable_d = 1'b0;
        clear_s  = 1'b0;

        // Saturated or conflicting requests are dropped and leave the counters alone.
        up_ok_s = up_p & ~dn_p & (speed_q != SPEED_MAX);
        dn_ok_s = dn_p & ~up_p & (speed_q != SPEED_MIN);
        if (up_ok_s) begin
            speed_d = speed_q + 3'd1;
        end else if (dn_ok_s) begin
            speed_d = speed_q - 3'd1;
        end else begin
            speed_d = speed_q;
        end

        base_wrap_s   = (base_cnt_q == BASE_LAST);
        period_wrap_s = base_wrap_s & (tick_cnt_q == tick_limit(speed_q));

        case (state_q)
            ST_PAUSE: begin
                if (run_p) begin
                    state_d = ST_RUN;
                    clear_s = 1'b1;
                end else begin
                    enable_d = step_p;
                end
            end
            ST_RUN: begin
                // A pause request on a wrap cycle swallows that strobe.
                if (run_p) begin
                    state_d = ST_PAUSE;
                end else begin
                    enable_d = period_wrap_s;
                end
            end
            default: begin
                state_d = ST_PAUSE;
            end
        endcase

        if (clear_s || up_ok_s || dn_ok_s) begin
            base_cnt_d = '0;
            tick_cnt_d = 3'd0;
        end else if (state_q == ST_RUN) begin
            base_cnt_d = base_wrap_s ? '0 : (base_cnt_q + BASE_W'(1));
            if (period_wrap_s) begin
                tick_cnt_d = 3'd0;
            end else if (base_wrap_s) begin
                tick_cnt_d = tick_cnt_q + 3'd1;
            end else begin
                tick_cnt_d = tick_cnt_q;
            end
        end else begin
            base_cnt_d = base_cnt_q;
            tick_cnt_d = tick_cnt_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_PAUSE;
            speed_q    <= SPEED_W'(SPEED_RST);
            base_cnt_q <= '0;
            tick_cnt_q <= 3'd0;
            enable_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            speed_q    <= speed_d;
            base_cnt_q <= base_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            enable_q   <= enable_d;
        end
    end

    assign ENABLE  = enable_q;
    assign SPEED   = speed_q;
    assign RUNNING = (state_q == ST_RUN);

endmodule
